// File: rtl/weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_loader_pkg
//   Shared definitions for the weight loader: FSM state encoding and helpers
//   that derive the bytes-per-word and write-address width from the module
//   parameters.
// -----------------------------------------------------------------------------
package weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of stream bytes that make up one weight word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Address width for a memory of n words; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// weight_loader_byte_packer
//   Packs an 8-bit stream into DATA_WIDTH words, MSB first. The earlier bytes
//   of a word sit in a shift register; the final byte is combined straight
//   from din, so word/word_valid are valid in the same cycle the last byte of
//   a word is accepted. Used for both weight data and the trailing checksum.
//   DATA_WIDTH must be a multiple of 8 and at least 16.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   clear       drop any partial word and restart at byte 0
//   accept      a byte is taken this cycle (valid & ready)
//   din         stream byte
//   word        packed word (meaningful when word_valid)
//   word_valid  last byte of a word accepted this cycle
// -----------------------------------------------------------------------------
module weight_loader_byte_packer
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            din,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam int IW    = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam int SW    = DATA_WIDTH - 8;

  logic [SW-1:0] shreg_q, shreg_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic          last_byte;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    last_byte  = (byte_idx_q == IW'(BYTES - 1));
    word       = {shreg_q, din};
    word_valid = accept && last_byte;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      shreg_d    = '0;
      byte_idx_d = '0;
    end else if (accept) begin
      // Keep only the bytes that still precede the next incoming one.
      shreg_d    = word[SW-1:0];
      byte_idx_d = last_byte ? '0 : byte_idx_q + IW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//   Write-side initiator for a neuron weight memory. Packs a byte stream into
//   DATA_WIDTH words (MSB first) and writes them to addresses 0..N_WEIGHT-1,
//   pulsing done once a full set has been written.
//   Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to accept a trailing
//   DATA_WIDTH checksum (sum of all written words mod 2^DATA_WIDTH); a
//   mismatch sets error. Without it the FSM goes LOAD -> DONE directly.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load (only honoured in IDLE)
//   abort           cancel a load in progress (LOAD/CHECK)
//   din/din_valid   byte stream in; din_ready is the registered accept
//   wen/wadd/win    memory write port, one wen cycle per word
//   busy            high while in LOAD or CHECK
//   done            one-cycle pulse at the end of a load
//   error           sticky; set by abort or checksum mismatch, cleared by start
// -----------------------------------------------------------------------------
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter  int N_WEIGHT   = 256,
  parameter  int DATA_WIDTH = 16,
  localparam int AW         = addr_width(N_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  wen,
  output logic [AW-1:0]         wadd,
  output logic [DATA_WIDTH-1:0] win,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t state_q, state_d;

  logic                  din_ready_q, din_ready_d;
  logic                  wen_q, wen_d;
  logic [AW-1:0]         wadd_q, wadd_d;
  logic [DATA_WIDTH-1:0] win_q, win_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [AW-1:0]         addr_q, addr_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  chk_end;
`endif

  logic                  accept;
  logic                  start_go;
  logic                  abort_go;
  logic                  last_word;
  logic                  load_end;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  pk_valid;

  assign accept   = din_valid && din_ready_q;
  assign start_go = start && (state_q == ST_IDLE);
  assign abort_go = abort && ((state_q == ST_LOAD) || (state_q == ST_CHECK));
  // The final word completes this cycle: stop accepting at the next edge.
  assign last_word = (state_q == ST_LOAD) && pk_valid && (addr_q == AW'(N_WEIGHT - 1));
  // The final write is on the port this cycle: leave LOAD at the next edge.
  assign load_end  = (state_q == ST_LOAD) && wen_q && (wadd_q == AW'(N_WEIGHT - 1));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign chk_end   = (state_q == ST_CHECK) && pk_valid;
`endif

  weight_loader_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go || abort_go),
    .accept     (accept),
    .din        (din),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_go) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort_go) state_d = ST_IDLE;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        else if (load_end) state_d = ST_CHECK;
`else
        else if (load_end) state_d = ST_DONE;
`endif
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (abort_go)     state_d = ST_IDLE;
        else if (chk_end) state_d = ST_DONE;
      end
`else
      ST_CHECK: state_d = ST_IDLE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and datapath (all outputs leave the block registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    wen_d   = 1'b0;
    wadd_d  = wadd_q;
    win_d   = win_q;
    addr_d  = addr_q;
    error_d = error_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    if (start_go) begin
      error_d = 1'b0;
      addr_d  = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end

    // Abort wins over a word completing in the same cycle: that word is dropped.
    if (abort_go) begin
      error_d = 1'b1;
    end else if ((state_q == ST_LOAD) && pk_valid) begin
      wen_d  = 1'b1;
      wadd_d = addr_q;
      win_d  = pk_word;
      addr_d = addr_q + AW'(1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_d  = sum_q + pk_word;
`endif
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    else if (chk_end && (pk_word != sum_q)) begin
      error_d = 1'b1;
    end
`endif

    din_ready_d = ((state_d == ST_LOAD) && !last_word) || (state_d == ST_CHECK);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_ready_q <= 1'b0;
      wen_q       <= 1'b0;
      wadd_q      <= '0;
      win_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      din_ready_q <= din_ready_d;
      wen_q       <= wen_d;
      wadd_q      <= wadd_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      addr_q      <= addr_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign din_ready = din_ready_q;
  assign wen       = wen_q;
  assign wadd      = wadd_q;
  assign win       = win_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//   Directed bench for weight_loader with N_WEIGHT=4, DATA_WIDTH=16.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Define WEIGHT_LOADER_CHECKSUM_EN for both bench and RTL to cover the
//   checksum build.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        wen;
  logic [1:0]  wadd;
  logic [15:0] win;
  logic        busy;
  logic        done;
  logic        error;

  weight_loader #(
    .N_WEIGHT   (4),
    .DATA_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .wen       (wen),
    .wadd      (wadd),
    .win       (win),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Write/done monitor
  logic [1:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (wen) begin
      wr_addr.push_back(wadd);
      wr_data.push_back(win);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  logic [7:0]  stim  [0:7];
  logic [15:0] exp_w [0:3];
  int          acc_cyc [0:9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    acc       = -1;
    din       = b;
    din_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (din_ready) begin
        acc = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din       = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  // Send stim[lo..hi]; gap idle cycles after every byte, first_gap after byte 0.
  task automatic load_range(input int lo, input int hi, input int gap, input int first_gap);
    for (int i = lo; i <= hi; i++) begin
      send_byte(stim[i], acc_cyc[i]);
      if (i == 0 && first_gap > 0) idle(first_gap);
      else if (gap > 0 && i < hi)  idle(gap);
    end
    din_valid = 1'b0;
  endtask

  // After the last data byte: checksum bytes (checksum build), then settle.
  task automatic finish_load(input logic [15:0] chk);
    check("ready_low_after_last", {31'd0, din_ready}, 32'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send_byte(chk[15:8], acc_cyc[8]);
    send_byte(chk[7:0], acc_cyc[9]);
    din_valid = 1'b0;
`else
    if (chk == 16'h0) din = 8'h00;  // checksum unused in this build
`endif
    idle(4);
  endtask

  task automatic verify_full(input string tag);
    int exp_done;
    check($sformatf("%s_wr_count", tag), wr_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), {30'd0, wr_addr[i]}, i);
        check($sformatf("%s_data%0d", tag, i), {16'd0, wr_data[i]}, {16'd0, exp_w[i]});
        check($sformatf("%s_wcyc%0d", tag, i), wr_cyc[i], acc_cyc[2*i+1] + 1);
      end
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    exp_done = acc_cyc[9] + 1;
`else
    exp_done = acc_cyc[7] + 2;
`endif
    check($sformatf("%s_done_count", tag), done_cyc.size(), 32'd1);
    if (done_cyc.size() > 0) check($sformatf("%s_done_cyc", tag), done_cyc[0], exp_done);
    check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_ready", tag), {31'd0, din_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    stim  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wen",   {31'd0, wen},       32'd0);
    check("rst_wadd",  {30'd0, wadd},      32'd0);
    check("rst_win",   {16'd0, win},       32'd0);
    check("rst_ready", {31'd0, din_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_error", {31'd0, error},     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Idle: bytes are not consumed
    din_valid = 1'b1;
    din       = 8'h55;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, din_ready}, 32'd0);
    idle(1);

    // 1: back-to-back load; sum 1234+5678+9ABC+DEF0 = E258 (mod 2^16)
    clear_mon();
    pulse_start();
    check("t1_busy",  {31'd0, busy},      32'd1);
    check("t1_ready", {31'd0, din_ready}, 32'd1);
    load_range(0, 7, 0, 0);
    finish_load(16'hE258);
    verify_full("t1");
    check("t1_error", {31'd0, error}, 32'd0);
    // Extra bytes are never accepted
    din_valid = 1'b1;
    din       = 8'hAA;
    repeat (3) @(negedge clk);
    check("t1_extra_ready", {31'd0, din_ready}, 32'd0);
    check("t1_extra_wr",    wr_addr.size(),     32'd4);
    idle(1);

    // 2: din_valid toggling, long gap between 12 and 34
    clear_mon();
    pulse_start();
    load_range(0, 7, 1, 3);
    finish_load(16'hE258);
    verify_full("t2");

    // 3: start during LOAD is ignored
    clear_mon();
    pulse_start();
    load_range(0, 2, 0, 0);
    idle(1);
    pulse_start();
    check("t3_busy",  {31'd0, busy},  32'd1);
    check("t3_error", {31'd0, error}, 32'd0);
    load_range(3, 7, 0, 0);
    finish_load(16'hE258);
    verify_full("t3");
    check("t3_error_end", {31'd0, error}, 32'd0);

    // 4: abort after 5 bytes
    clear_mon();
    pulse_start();
    load_range(0, 4, 0, 0);
    pulse_abort();
    check("t4_busy",  {31'd0, busy},      32'd0);
    check("t4_ready", {31'd0, din_ready}, 32'd0);
    check("t4_error", {31'd0, error},     32'd1);
    idle(3);
    check("t4_wr_count", wr_addr.size(), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("t4_addr0", {30'd0, wr_addr[0]}, 32'd0);
      check("t4_data0", {16'd0, wr_data[0]}, 32'h1234);
      check("t4_addr1", {30'd0, wr_addr[1]}, 32'd1);
      check("t4_data1", {16'd0, wr_data[1]}, 32'h5678);
    end
    check("t4_no_done", done_cyc.size(), 32'd0);
    // start and abort together in IDLE: start wins and clears error
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t4_sa_busy",  {31'd0, busy},  32'd1);
    check("t4_sa_error", {31'd0, error}, 32'd0);
    pulse_abort();
    check("t4_ab2_error", {31'd0, error}, 32'd1);
    check("t4_ab2_busy",  {31'd0, busy},  32'd0);

    // 5: reset mid-load, then a fresh load; sum 1122+3344+5566+7788 = 1154
    clear_mon();
    pulse_start();
    load_range(0, 2, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy",  {31'd0, busy},      32'd0);
    check("t5_rst_ready", {31'd0, din_ready}, 32'd0);
    check("t5_rst_error", {31'd0, error},     32'd0);
    stim  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_w = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    clear_mon();
    pulse_start();
    load_range(0, 7, 0, 0);
    finish_load(16'h1154);
    verify_full("t5");

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // 6: wrong checksum sets error, done still pulses
    stim  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    clear_mon();
    pulse_start();
    load_range(0, 7, 0, 0);
    finish_load(16'hE259);
    verify_full("t6");
    check("t6_error", {31'd0, error}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
